// File: rtl/wash_pkg.sv
// Shared types and constants for the washing-machine phase timer.
package wash_pkg;

  // Timer state encoding; also used as the decoded-phase type
  // (ST_IDLE doubles as "no run phase decoded").
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WASH  = 3'd1,
    ST_RINSE = 3'd2,
    ST_SPIN  = 3'd3,
    ST_HOLD  = 3'd4
  } wash_state_e;

  // Watchdog fault codes.
  localparam logic [1:0] FLT_NONE  = 2'b00;
  localparam logic [1:0] FLT_FILL  = 2'b01;
  localparam logic [1:0] FLT_DRAIN = 2'b10;

  // Default parameter values.
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_PRESCALE = 1000;
  localparam int DEF_WD_TICKS = 500;

  // True for the three states that count down a duration.
  function automatic logic is_run_state(input wash_state_e s);
    logic r;
    case (s)
      ST_WASH, ST_RINSE, ST_SPIN: r = 1'b1;
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wash_tick_prescaler.sv
// Divides clk down to a one-clock tick every PRESCALE clocks.
// The tick is high while the counter sits at PRESCALE-1; clr restarts the count.
module wash_tick_prescaler
  import wash_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] cnt_q;
  logic [PS_W-1:0] cnt_d;

  assign tick = (cnt_q == PS_LAST);

  // Next count: clear on request, wrap after the last count, else increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PS_W'(1);
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wash_phase_timer.sv
// Phase timer for the washing-machine FSM: decodes the FSM status into
// wash/rinse/spin, loads the matching duration, counts prescaled ticks and
// returns one-clock cycle_timeout / spin_timeout pulses.
// Optional valve watchdog enabled by defining WASH_WATCHDOG_EN.
module wash_phase_timer
  import wash_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int WD_TICKS = DEF_WD_TICKS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             door_lock,
  input  logic             motor_on,
  input  logic             soap_wash,
  input  logic             water_wash,
  input  logic             fill_value_on,
  input  logic             drain_value_on,
  input  logic [CNT_W-1:0] wash_ticks,
  input  logic [CNT_W-1:0] rinse_ticks,
  input  logic [CNT_W-1:0] spin_ticks,
  input  logic             fault_clr,
  output logic             cycle_timeout,
  output logic             spin_timeout,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] remaining,
  output logic             fault,
  output logic [1:0]       fault_code
);

  wash_state_e      dec_s;
  wash_state_e      state_q, state_d;
  wash_state_e      held_q, held_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] load_ticks_s;
  logic             cycle_timeout_q, cycle_timeout_d;
  logic             spin_timeout_q, spin_timeout_d;
  logic             ps_clr_s;
  logic             tick_s;

  wash_tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (ps_clr_s),
    .tick  (tick_s)
  );

  // Decode the FSM status into the active phase; first match wins.
  always_comb begin
    dec_s = ST_IDLE;
    if (door_lock && motor_on) begin
      if (soap_wash) begin
        dec_s = ST_WASH;
      end else if (water_wash) begin
        dec_s = ST_RINSE;
      end else begin
        dec_s = ST_SPIN;
      end
    end else begin
      dec_s = ST_IDLE;
    end
  end

  // Select the duration for the decoded phase (only used at load time).
  always_comb begin
    case (dec_s)
      ST_WASH:  load_ticks_s = wash_ticks;
      ST_RINSE: load_ticks_s = rinse_ticks;
      ST_SPIN:  load_ticks_s = spin_ticks;
      default:  load_ticks_s = '0;
    endcase
  end

  // Next-state, countdown and timeout-pulse logic. A phase change always
  // wins over an expiry on the same edge, so a change never pulses.
  always_comb begin
    state_d         = state_q;
    held_d          = held_q;
    remaining_d     = remaining_q;
    cycle_timeout_d = 1'b0;
    spin_timeout_d  = 1'b0;
    ps_clr_s        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dec_s != ST_IDLE) begin
          state_d     = dec_s;
          remaining_d = load_ticks_s;
          ps_clr_s    = 1'b1;
        end else begin
          remaining_d = '0;
        end
      end
      ST_HOLD: begin
        // Wait for the status to move away from the phase that expired.
        if (dec_s == held_q) begin
          remaining_d = '0;
        end else if (dec_s != ST_IDLE) begin
          state_d     = dec_s;
          remaining_d = load_ticks_s;
          ps_clr_s    = 1'b1;
        end else begin
          state_d     = ST_IDLE;
          remaining_d = '0;
        end
      end
      ST_WASH, ST_RINSE, ST_SPIN: begin
        if (dec_s != state_q) begin
          if (dec_s == ST_IDLE) begin
            state_d     = ST_IDLE;
            remaining_d = '0;
          end else begin
            state_d     = dec_s;
            remaining_d = load_ticks_s;
            ps_clr_s    = 1'b1;
          end
        end else if (remaining_q == '0) begin
          state_d     = ST_HOLD;
          held_d      = state_q;
          remaining_d = '0;
          if (state_q == ST_SPIN) begin
            spin_timeout_d = 1'b1;
          end else begin
            cycle_timeout_d = 1'b1;
          end
        end else if (tick_s) begin
          remaining_d = remaining_q - CNT_W'(1);
        end else begin
          remaining_d = remaining_q;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        remaining_d = '0;
      end
    endcase
  end

  // Timer state, countdown and pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      held_q          <= ST_IDLE;
      remaining_q     <= '0;
      cycle_timeout_q <= 1'b0;
      spin_timeout_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      held_q          <= held_d;
      remaining_q     <= remaining_d;
      cycle_timeout_q <= cycle_timeout_d;
      spin_timeout_q  <= spin_timeout_d;
    end
  end

  assign cycle_timeout = cycle_timeout_q;
  assign spin_timeout  = spin_timeout_q;
  assign phase         = state_q;
  assign remaining     = remaining_q;

`ifdef WASH_WATCHDOG_EN

  localparam int WD_W = (WD_TICKS > 0) ? $clog2(WD_TICKS + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(WD_TICKS);

  logic            fill_prev_q, drain_prev_q;
  logic [WD_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [WD_W-1:0] drain_cnt_q, drain_cnt_d;
  logic            fault_q, fault_d;
  logic [1:0]      fault_code_q, fault_code_d;
  logic            fill_trip_s, drain_trip_s, offender_open_s;

  // Open-time counter step: restart on valve rising edge, count ticks
  // while open, saturate at the limit.
  function automatic logic [WD_W-1:0] wd_next(input logic valve, input logic prev,
                                               input logic tick, input logic [WD_W-1:0] cnt);
    logic [WD_W-1:0] n;
    if (valve && !prev) begin
      n = '0;
    end else if (valve && tick && (cnt < WD_LIM)) begin
      n = cnt + WD_W'(1);
    end else begin
      n = cnt;
    end
    return n;
  endfunction

  // Valve open-time counters and trip detection.
  always_comb begin
    fill_cnt_d   = wd_next(fill_value_on, fill_prev_q, tick_s, fill_cnt_q);
    drain_cnt_d  = wd_next(drain_value_on, drain_prev_q, tick_s, drain_cnt_q);
    fill_trip_s  = fill_value_on && (fill_cnt_d >= WD_LIM);
    drain_trip_s = drain_value_on && (drain_cnt_d >= WD_LIM);
  end

  // Latched fault: clear only once the offending valve has closed.
  always_comb begin
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    case (fault_code_q)
      FLT_FILL:  offender_open_s = fill_value_on;
      FLT_DRAIN: offender_open_s = drain_value_on;
      default:   offender_open_s = 1'b0;
    endcase
    if (fault_q) begin
      if (fault_clr && !offender_open_s) begin
        fault_d      = 1'b0;
        fault_code_d = FLT_NONE;
      end else begin
        fault_d      = 1'b1;
      end
    end else if (fill_trip_s) begin
      fault_d      = 1'b1;
      fault_code_d = FLT_FILL;
    end else if (drain_trip_s) begin
      fault_d      = 1'b1;
      fault_code_d = FLT_DRAIN;
    end else begin
      fault_d      = 1'b0;
      fault_code_d = FLT_NONE;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_prev_q  <= 1'b0;
      drain_prev_q <= 1'b0;
      fill_cnt_q   <= '0;
      drain_cnt_q  <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= FLT_NONE;
    end else begin
      fill_prev_q  <= fill_value_on;
      drain_prev_q <= drain_value_on;
      fill_cnt_q   <= fill_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign fault      = fault_q;
  assign fault_code = fault_code_q;

`else

  localparam int unused_wd_ticks = WD_TICKS;
  logic unused_wd_inputs_s;

  assign unused_wd_inputs_s = fault_clr ^ fill_value_on ^ drain_value_on;
  assign fault              = 1'b0;
  assign fault_code         = FLT_NONE;

`endif

endmodule

// File: tb/tb_wash_phase_timer.sv
// Scoreboard bench for wash_phase_timer: expected timeout pulses are queued
// by the stimulus and popped by a monitor whenever a DUT pulses.
// d1 runs with PRESCALE=1 / WD_TICKS=10, d4 with PRESCALE=4.
module tb_wash_phase_timer;

  typedef struct {
    bit spin;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        door1 = 1'b0, motor1 = 1'b0, soap1 = 1'b0, water1 = 1'b0;
  logic        door4 = 1'b0, motor4 = 1'b0, soap4 = 1'b0, water4 = 1'b0;
  logic        fill = 1'b0, drain = 1'b0, fault_clr = 1'b0;
  logic [15:0] wash_ticks = 16'd0, rinse_ticks = 16'd0, spin_ticks = 16'd0;

  logic        d1_cto, d1_sto, d1_fault, d4_cto, d4_sto, d4_fault;
  logic [2:0]  d1_phase, d4_phase;
  logic [15:0] d1_rem, d4_rem;
  logic [1:0]  d1_code, d4_code;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   e0 = 0;
  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;

`ifdef WASH_WATCHDOG_EN
  localparam int WD_ON = 1;
`else
  localparam int WD_ON = 0;
`endif

  wash_phase_timer #(.CNT_W(16), .PRESCALE(1), .WD_TICKS(10)) d1 (
    .clk(clk), .reset(reset), .door_lock(door1), .motor_on(motor1),
    .soap_wash(soap1), .water_wash(water1), .fill_value_on(fill),
    .drain_value_on(drain), .wash_ticks(wash_ticks), .rinse_ticks(rinse_ticks),
    .spin_ticks(spin_ticks), .fault_clr(fault_clr), .cycle_timeout(d1_cto),
    .spin_timeout(d1_sto), .phase(d1_phase), .remaining(d1_rem),
    .fault(d1_fault), .fault_code(d1_code)
  );

  wash_phase_timer #(.CNT_W(16), .PRESCALE(4), .WD_TICKS(500)) d4 (
    .clk(clk), .reset(reset), .door_lock(door4), .motor_on(motor4),
    .soap_wash(soap4), .water_wash(water4), .fill_value_on(fill),
    .drain_value_on(drain), .wash_ticks(wash_ticks), .rinse_ticks(rinse_ticks),
    .spin_ticks(spin_ticks), .fault_clr(fault_clr), .cycle_timeout(d4_cto),
    .spin_timeout(d4_sto), .phase(d4_phase), .remaining(d4_rem),
    .fault(d4_fault), .fault_code(d4_code)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set1(input logic d, input logic m, input logic s, input logic w);
    door1 = d; motor1 = m; soap1 = s; water1 = w;
  endtask

  // Monitor for d1 pulses.
  initial forever begin
    @(negedge clk);
    if (!reset && (d1_cto || d1_sto)) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL d1_pulse: got cto=%0b sto=%0b at cycle %0d, expected no pulse", d1_cto, d1_sto, cyc);
      end else begin
        e1 = q1.pop_front();
        if (d1_sto != e1.spin || d1_cto == e1.spin || cyc != e1.cyc) begin
          bad++;
          $display("FAIL d1_pulse: got cto=%0b sto=%0b at cycle %0d, expected spin=%0b at cycle %0d",
                   d1_cto, d1_sto, cyc, e1.spin, e1.cyc);
        end
      end
    end
  end

  // Monitor for d4 pulses.
  initial forever begin
    @(negedge clk);
    if (!reset && (d4_cto || d4_sto)) begin
      total++;
      if (q4.size() == 0) begin
        bad++;
        $display("FAIL d4_pulse: got cto=%0b sto=%0b at cycle %0d, expected no pulse", d4_cto, d4_sto, cyc);
      end else begin
        e4 = q4.pop_front();
        if (d4_sto != e4.spin || d4_cto == e4.spin || cyc != e4.cyc) begin
          bad++;
          $display("FAIL d4_pulse: got cto=%0b sto=%0b at cycle %0d, expected spin=%0b at cycle %0d",
                   d4_cto, d4_sto, cyc, e4.spin, e4.cyc);
        end
      end
    end
  end

  initial begin
    #1 reset = 1'b1;
    step(2);
    chk("rst_phase", d1_phase, 0);
    chk("rst_rem", d1_rem, 0);
    chk("rst_cto", d1_cto, 0);
    chk("rst_sto", d1_sto, 0);
    chk("rst_fault", d1_fault, 0);
    chk("rst_code", d1_code, 0);
    chk("rst_d4_phase", d4_phase, 0);
    reset = 1'b0;
    step(1);

    // Wash N=5, P=1: pulse after e0+6, then HOLD without re-pulse.
    wash_ticks = 16'd5;
    set1(1'b1, 1'b1, 1'b1, 1'b0);
    step(1); e0 = cyc;
    chk("wash_load_phase", d1_phase, 1);
    chk("wash_load_rem", d1_rem, 5);
    q1.push_back('{1'b0, e0 + 6});
    wash_ticks = 16'd100;
    step(3);
    chk("wash_rem_mid", d1_rem, 2);
    step(3);
    chk("wash_hold_phase", d1_phase, 4);
    chk("wash_hold_rem", d1_rem, 0);
    step(20);
    chk("wash_hold_stay", d1_phase, 4);
    set1(1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    chk("hold_to_idle", d1_phase, 0);

    // Rinse N=2: pulse after e0+3.
    rinse_ticks = 16'd2;
    set1(1'b1, 1'b1, 1'b0, 1'b1);
    step(1); e0 = cyc;
    chk("rinse_load_phase", d1_phase, 2);
    chk("rinse_load_rem", d1_rem, 2);
    q1.push_back('{1'b0, e0 + 3});
    step(3);
    chk("rinse_hold_phase", d1_phase, 4);
    set1(1'b0, 1'b0, 1'b0, 1'b0);
    step(1);

    // Wash -> rinse switch mid-run reloads without a pulse; then reset.
    wash_ticks = 16'd5;
    set1(1'b1, 1'b1, 1'b1, 1'b0);
    step(4);
    chk("sw_wash_rem", d1_rem, 2);
    rinse_ticks = 16'd7;
    set1(1'b1, 1'b1, 1'b0, 1'b1);
    step(1);
    chk("sw_phase", d1_phase, 2);
    chk("sw_rem", d1_rem, 7);
    step(3);
    chk("sw_rem_run", d1_rem, 4);
    #2 reset = 1'b1;
    #1;
    chk("arst_phase", d1_phase, 0);
    chk("arst_rem", d1_rem, 0);
    chk("arst_cto", d1_cto, 0);
    chk("arst_sto", d1_sto, 0);
    chk("arst_fault", d1_fault, 0);
    set1(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step(3);
    chk("post_rst_phase", d1_phase, 0);
    chk("post_rst_rem", d1_rem, 0);

    // Zero duration: pulse after e0+1.
    wash_ticks = 16'd0;
    set1(1'b1, 1'b1, 1'b1, 1'b0);
    step(1); e0 = cyc;
    chk("zero_phase", d1_phase, 1);
    chk("zero_rem", d1_rem, 0);
    q1.push_back('{1'b0, e0 + 1});
    step(2);
    chk("zero_hold", d1_phase, 4);
    set1(1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    chk("zero_idle", d1_phase, 0);

    // Door unlock mid-phase: back to IDLE, no pulse.
    wash_ticks = 16'd5;
    set1(1'b1, 1'b1, 1'b1, 1'b0);
    step(3);
    chk("drop_rem", d1_rem, 3);
    door1 = 1'b0;
    step(1);
    chk("drop_phase", d1_phase, 0);
    chk("drop_rem0", d1_rem, 0);
    step(10);
    chk("drop_stay", d1_phase, 0);
    set1(1'b0, 1'b0, 1'b0, 1'b0);

    // Spin N=3 at P=4: remaining 3,2,1,0 every 4 clocks, pulse after e0+13.
    spin_ticks = 16'd3;
    door4 = 1'b1; motor4 = 1'b1;
    step(1); e0 = cyc;
    chk("spin_phase", d4_phase, 3);
    q4.push_back('{1'b1, e0 + 13});
    for (int k = 0; k <= 12; k++) begin
      chk($sformatf("spin_rem_k%0d", k), d4_rem, 3 - k / 4);
      step(1);
    end
    chk("spin_hold", d4_phase, 4);
    door4 = 1'b0; motor4 = 1'b0;
    step(1);

    // Valve watchdog (WD_TICKS=10, P=1).
    fill = 1'b1;
    step(10);
    chk("wd_fill_pre", d1_fault, 0);
    step(1);
    chk("wd_fill_fault", d1_fault, WD_ON);
    chk("wd_fill_code", d1_code, WD_ON);
    fault_clr = 1'b1;
    step(1);
    chk("wd_clr_open", d1_fault, WD_ON);
    fault_clr = 1'b0; fill = 1'b0;
    step(1);
    chk("wd_closed_held", d1_fault, WD_ON);
    fault_clr = 1'b1;
    step(1);
    chk("wd_clr_fault", d1_fault, 0);
    chk("wd_clr_code", d1_code, 0);
    fault_clr = 1'b0;
    drain = 1'b1;
    step(11);
    chk("wd_drain_fault", d1_fault, WD_ON);
    chk("wd_drain_code", d1_code, 2 * WD_ON);
    drain = 1'b0; fault_clr = 1'b1;
    step(1);
    chk("wd_drain_clr", d1_fault, 0);
    fault_clr = 1'b0;

    step(5);
    chk("d1_pending", q1.size(), 0);
    chk("d4_pending", q4.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
